capture_buffer: RTL
===================

Name: capture_buffer

Overview:
Multi-channel, pre-/post-trigger circular capture buffer for the HSMC ADC sample path. Continuously records NUM_CH parallel channels into a ring while armed. It freezes a record window around a threshold crossing on a selected channel. The record is then read out oldest-first over a valid/ready stream to the pulse-analysis logic.

Parameters:
NUM_CH, 2, number of parallel ADC channels stored per sample word
DWIDTH, 14, bits per channel sample (unsigned)
MAX_SAMPLES, 64, ring depth in sample words; need not be a power of two
ADDR_BITS, $clog2(MAX_SAMPLES), pointer width

Ports:
CLOCK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
ENABLE  in  1  sample strobe; DATA_IN is valid when high
DATA_IN  in  NUM_CH*DWIDTH  channel k at bits [k*DWIDTH +: DWIDTH]
ARM  in  1  start a capture (honoured in IDLE only)
ABORT  in  1  cancel any activity and return to IDLE
TRIG_SEL  in  $clog2(NUM_CH) (min 1)  trigger channel index
THRESHOLD  in  DWIDTH  trigger level
PRE_LEN  in  ADDR_BITS  samples kept before the trigger
POST_LEN  in  ADDR_BITS+1  samples kept from the trigger sample onward
RD_READY  in  1  downstream accepts a word
RD_VALID  out  1  RD_DATA is valid
RD_DATA  out  NUM_CH*DWIDTH  readout sample word
RD_LAST  out  1  marks the final word of the record
BUSY  out  1  high in any state except IDLE
TRIGGERED  out  1  high from trigger until the end of readout
DONE  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset:
  - state = IDLE; all outputs 0; pointers and counters 0.
  - Memory contents are not reset; an implementation that allows RAM inference is required.
- ARM in IDLE latches the window lengths:
  - PRE_LEN is clamped to MAX_SAMPLES-1.
  - POST_LEN is clamped to the range 1 .. MAX_SAMPLES-PRE_LEN.
  - TRIG_SEL and THRESHOLD are latched.
  - Write pointer and fill counter are cleared; state -> PRE.
  - ARM in any other state is ignored.
- States:
  - IDLE: no writes.
  - PRE: each ENABLE writes DATA_IN at wr_ptr, then wr_ptr = (wr_ptr+1) mod MAX_SAMPLES and fill is incremented. When fill reaches the latched PRE_LEN -> WAIT. If PRE_LEN=0, PRE moves straight to WAIT on the next cycle.
  - WAIT: the ring keeps writing on each ENABLE. A trigger is a rising crossing on the selected channel: the current sample is > THRESHOLD and the previous sample on that channel was <= THRESHOLD. The previous sample is tracked from PRE onward; the first sample after ARM counts as having a previous sample of 0. The trigger sample itself is written and counted as post-sample #1. TRIGGERED goes high. start_ptr = (trig_addr - PRE_LEN) mod MAX_SAMPLES. State -> POST, or -> READOUT when POST_LEN=1.
  - POST: keep writing until POST_LEN samples have been stored including the trigger sample, then -> READOUT.
  - READOUT:
    - The first RD_VALID appears 1 cycle after entry (synchronous memory read).
    - Words are produced from start_ptr upward with wrap-around, PRE_LEN+POST_LEN words in total.
    - RD_DATA and RD_LAST are held stable while RD_VALID=1 and RD_READY=0.
    - With RD_READY held high, one word is transferred per cycle and there are no bubbles.
    - ENABLE is ignored here; those samples are dropped.
    - After the RD_LAST word is accepted: RD_VALID=0 and TRIGGERED=0 on the next edge, DONE pulses for one cycle, state -> IDLE.
- ABORT takes priority over everything except RESET. From any state, the next edge goes to IDLE with RD_VALID, RD_LAST, TRIGGERED and DONE cleared; no DONE pulse is issued.
- ARM and ABORT high in the same cycle: ABORT wins.
- A trigger condition in PRE is ignored; the pre-trigger history must be full first.
- All comparisons are unsigned at DWIDTH bits. Pointer arithmetic is modulo MAX_SAMPLES, correct for non-power-of-two depth.

Optional Feature:
CAPTURE_TIMESTAMP_EN:
- Defined: adds output TRIG_TIMESTAMP [31:0].
  - A free-running 32-bit counter, reset to 0, increments on every ENABLE regardless of state and wraps silently.
  - Its value for the trigger sample is latched at trigger.
  - TRIG_TIMESTAMP holds that value until the next trigger; it resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- PRE_LEN=4, POST_LEN=4, TRIG_SEL=0, THRESHOLD=100, ch0 ramp 0,20,40,... per ENABLE, RD_READY=1 -> trigger on ch0=120. Readout is 8 words with ch0 = 40,60,80,100,120,140,160,180. RD_LAST on word 8, DONE pulse, BUSY falls.
- PRE_LEN=10, POST_LEN=60, MAX_SAMPLES=64 -> POST_LEN clamped to 54. Exactly 64 words read; start_ptr wraps correctly across address 63->0.
- RD_READY toggled 1,0,0,1 pattern during readout -> RD_DATA stable while stalled; no word lost or duplicated; sequence matches the written data.
- Signal already >THRESHOLD at ARM, rising crossing occurs during PRE -> no trigger until after 4 pre-samples, then the next genuine rising crossing triggers.
- ABORT asserted mid-POST, then mid-READOUT with RD_READY=0 -> IDLE next edge, RD_VALID=0, no DONE. A subsequent ARM captures normally.
- RESET asserted asynchronously mid-READOUT -> all outputs 0 immediately, without waiting for a clock edge. With CAPTURE_TIMESTAMP_EN, trigger on the 37th ENABLE after reset -> TRIG_TIMESTAMP=36.

Source files
------------

// File: rtl/capture_buffer.sv
// Multi-channel pre-/post-trigger circular capture buffer with valid/ready readout.
// Optional trigger timestamp output when CAPTURE_TIMESTAMP_EN is defined.
module capture_buffer #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DWIDTH      = 14,
  parameter int unsigned MAX_SAMPLES = 64,
  parameter int unsigned ADDR_BITS   = $clog2(MAX_SAMPLES),
  parameter int unsigned SEL_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic                       ENABLE,
  input  logic [NUM_CH*DWIDTH-1:0]   DATA_IN,
  input  logic                       ARM,
  input  logic                       ABORT,
  input  logic [SEL_BITS-1:0]        TRIG_SEL,
  input  logic [DWIDTH-1:0]          THRESHOLD,
  input  logic [ADDR_BITS-1:0]       PRE_LEN,
  input  logic [ADDR_BITS:0]         POST_LEN,
  input  logic                       RD_READY,
  output logic                       RD_VALID,
  output logic [NUM_CH*DWIDTH-1:0]   RD_DATA,
  output logic                       RD_LAST,
  output logic                       BUSY,
  output logic                       TRIGGERED,
  output logic                       DONE
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]                TRIG_TIMESTAMP
`endif
);

  localparam int unsigned WordW = NUM_CH * DWIDTH;
  localparam int unsigned CntW  = ADDR_BITS + 1;
  localparam logic [CntW-1:0]      Depth    = CntW'(MAX_SAMPLES);
  localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(MAX_SAMPLES - 1);

  typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StReadout} state_e;

  state_e                 state_q;
  logic [ADDR_BITS-1:0]   wr_ptr_q, rd_ptr_q, start_ptr_q, pre_len_q;
  logic [CntW-1:0]        fill_q, post_len_q, rd_left_q;
  logic [SEL_BITS-1:0]    sel_q;
  logic [DWIDTH-1:0]      thr_q, prev_q;
  logic                   rd_valid_q, rd_last_q, triggered_q, done_q;
  logic [WordW-1:0]       rd_word_q;
  logic [WordW-1:0]       mem [MAX_SAMPLES];

  logic [DWIDTH-1:0]      cur_sample;
  logic [ADDR_BITS-1:0]   wr_ptr_inc, rd_ptr_inc, start_calc, pre_clamp;
  logic [CntW-1:0]        post_max, post_clamp, rec_len;
  logic                   trig_fire, wr_en, rd_fetch;

  always_comb begin
    cur_sample = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == SEL_BITS'(k)) cur_sample = DATA_IN[k*DWIDTH +: DWIDTH];
    end
  end

  assign wr_ptr_inc = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_inc = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
  // Modulo subtraction done at CntW bits so non-power-of-two depths wrap correctly
  assign start_calc = (wr_ptr_q >= pre_len_q) ? wr_ptr_q - pre_len_q :
                      ADDR_BITS'(CntW'(wr_ptr_q) + Depth - CntW'(pre_len_q));
  assign rec_len    = CntW'(pre_len_q) + post_len_q;

  assign pre_clamp  = (32'(PRE_LEN) > MAX_SAMPLES - 1) ? LastAddr : PRE_LEN;
  assign post_max   = Depth - CntW'(pre_clamp);
  assign post_clamp = (POST_LEN == '0)      ? CntW'(1) :
                      (POST_LEN > post_max) ? post_max : POST_LEN;

  assign trig_fire = !ABORT && (state_q == StWait) && ENABLE &&
                     (cur_sample > thr_q) && (prev_q <= thr_q);
  assign wr_en     = !ABORT && ENABLE &&
                     (((state_q == StPre) && (fill_q != CntW'(pre_len_q))) ||
                      (state_q == StWait) || (state_q == StPost));
  assign rd_fetch  = (state_q == StReadout) && (rd_left_q != '0) && (!rd_valid_q || RD_READY);

  // Sample RAM: no reset so it maps onto block memory
  always_ff @(posedge CLOCK) begin
    if (wr_en) mem[wr_ptr_q] <= DATA_IN;
    if (rd_fetch) rd_word_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      start_ptr_q <= '0;
      pre_len_q   <= '0;
      post_len_q  <= '0;
      fill_q      <= '0;
      rd_left_q   <= '0;
      sel_q       <= '0;
      thr_q       <= '0;
      prev_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ABORT) begin
        state_q     <= StIdle;
        rd_valid_q  <= 1'b0;
        rd_last_q   <= 1'b0;
        triggered_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (ARM) begin
              pre_len_q  <= pre_clamp;
              post_len_q <= post_clamp;
              sel_q      <= TRIG_SEL;
              thr_q      <= THRESHOLD;
              wr_ptr_q   <= '0;
              fill_q     <= '0;
              prev_q     <= '0;
              state_q    <= StPre;
            end
          end
          StPre: begin
            if (fill_q == CntW'(pre_len_q)) begin
              state_q <= StWait;
            end else if (ENABLE) begin
              wr_ptr_q <= wr_ptr_inc;
              fill_q   <= fill_q + 1'b1;
              prev_q   <= cur_sample;
              if (fill_q + 1'b1 == CntW'(pre_len_q)) state_q <= StWait;
            end
          end
          StWait: begin
            if (ENABLE) begin
              wr_ptr_q <= wr_ptr_inc;
              prev_q   <= cur_sample;
              if (trig_fire) begin
                triggered_q <= 1'b1;
                start_ptr_q <= start_calc;
                fill_q      <= CntW'(1);
                if (post_len_q == CntW'(1)) begin
                  rd_ptr_q  <= start_calc;
                  rd_left_q <= rec_len;
                  state_q   <= StReadout;
                end else begin
                  state_q <= StPost;
                end
              end
            end
          end
          StPost: begin
            if (ENABLE) begin
              wr_ptr_q <= wr_ptr_inc;
              fill_q   <= fill_q + 1'b1;
              if (fill_q + 1'b1 == post_len_q) begin
                rd_ptr_q  <= start_ptr_q;
                rd_left_q <= rec_len;
                state_q   <= StReadout;
              end
            end
          end
          StReadout: begin
            if (rd_fetch) begin
              rd_valid_q <= 1'b1;
              rd_last_q  <= (rd_left_q == CntW'(1));
              rd_ptr_q   <= rd_ptr_inc;
              rd_left_q  <= rd_left_q - 1'b1;
            end else if (rd_valid_q && RD_READY) begin
              // Only reached once the final word is being accepted
              rd_valid_q  <= 1'b0;
              rd_last_q   <= 1'b0;
              triggered_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_trig_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      ts_cnt_q  <= '0;
      ts_trig_q <= '0;
    end else begin
      if (ENABLE) ts_cnt_q <= ts_cnt_q + 32'd1;
      if (trig_fire) ts_trig_q <= ts_cnt_q;
    end
  end

  assign TRIG_TIMESTAMP = ts_trig_q;
`endif

  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_valid_q ? rd_word_q : '0;
  assign RD_LAST   = rd_last_q;
  assign BUSY      = (state_q != StIdle);
  assign TRIGGERED = triggered_q;
  assign DONE      = done_q;

endmodule
